fifo_param_sync: RTL and testbench
==================================

// Module: fifo_param_sync
// PURPOSE
//  Parametrised single-clock FIFO, next generation of the team's 16-bit FIFO.
//  Adds configurable depth (non-power-of-2 allowed), programmable almost-thresholds,
//  first-word-fall-through (FWFT) mode and an occupancy count output.
//  Keeps the existing status/handshake set: full/almost/empty/overflow/underflow/wr_ack.
// PARAMETERS
//  WIDTH     16  data word width, >=1
//  DEPTH     8   number of entries, >=2, any integer (wrap at DEPTH-1)
//  AF_LEVEL  DEPTH-1  almostfull asserted when count == AF_LEVEL
//  AE_LEVEL  1   almostempty asserted when count == AE_LEVEL
//  FWFT      0   0: registered read, 1-cycle latency; 1: head word visible while !empty
//  CW        $clog2(DEPTH+1)  derived, count width (localparam)
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous, active-low reset
//  data_in      in   WIDTH  write data
//  wr_en        in   1      write request
//  rd_en        in   1      read request
//  data_out     out  WIDTH  read data
//  full         out  1      count == DEPTH
//  almostfull   out  1      count == AF_LEVEL
//  empty        out  1      count == 0
//  almostempty  out  1      count == AE_LEVEL
//  overflow     out  1      registered: previous-cycle write rejected because full
//  underflow    out  1      registered: previous-cycle read rejected because empty
//  wr_ack       out  1      registered: previous-cycle write accepted
//  count        out  CW     current occupancy 0..DEPTH
// BEHAVIOUR
//  - Reset (rst_n=0, async): wr_ptr=rd_ptr=0, count=0, data_out=0, wr_ack=overflow=underflow=0;
//    empty=1, full=0, almostempty=(AE_LEVEL==0), almostfull=0. Memory contents not cleared.
//  - Write accepted iff wr_en && !full -> mem[wr_ptr]<=data_in, wr_ptr++, wr_ack=1 next cycle.
//  - wr_en && full -> no state change, overflow=1 next cycle, wr_ack=0.
//  - Read accepted iff rd_en && !empty -> rd_ptr++; FWFT=0: data_out<=mem[rd_ptr] next edge;
//    FWFT=1: data_out=mem[rd_ptr] combinationally while !empty, advances after edge.
//  - rd_en && empty -> underflow=1 next cycle, data_out holds its last value (FWFT=0).
//  - Simultaneous wr_en&&rd_en: neither full nor empty -> both happen, count unchanged;
//    full -> read only, overflow=1; empty -> write only, underflow=1.
//  - Pointer wrap: ptr==DEPTH-1 increments to 0 (explicit compare, not natural overflow).
//  - count: +1 on write-only, -1 on read-only, unchanged otherwise; never exceeds DEPTH.
//  - full/empty/almost* are combinational decodes of count (same-cycle as count update).
//  - wr_ack/overflow/underflow are one-cycle pulses, deasserted when no matching event.
//  - Reset asserted mid-operation: all state returns to reset values immediately;
//    first cycle after deassertion behaves as an empty FIFO.
//  - FWFT=1, empty: data_out is don't-care; bench checks it only when !empty.
//  Assertions (bound in bench): count<=DEPTH; !(full&&empty); wr_ack->!overflow.
// STRUCTURE
//  - fifo_pkg: FIFO_WIDTH_DEF=16, FIFO_DEPTH_DEF=8 constants; typedef fifo_status_t
//    packed struct {full,almostfull,empty,almostempty,overflow,underflow,wr_ack} for
//    scoreboard and coverage use.
//  - Sub-module fifo_wrap_ptr #(DEPTH): $clog2(DEPTH)-bit pointer, inc input, async
//    reset, wraps DEPTH-1 -> 0; instantiated twice (write and read).
//  - Storage: plain reg array, no reset; single always_ff for count and status pulses.
// TESTING
//  1 Reset then 8 writes (DEPTH=8) of 0x0001..0x0008 -> wr_ack each cycle, count 1..8,
//    almostfull at count 7, full at 8; 9th write -> overflow=1, count stays 8.
//  2 Drain 8 reads -> data_out 0x0001..0x0008 in order (1-cycle latency), almostempty
//    at count 1, empty at 0; 9th read -> underflow=1, data_out holds 0x0008.
//  3 DEPTH=5: 12 writes interleaved with reads keeping count 2..4 -> pointers wrap 4->0,
//    data order preserved, never full/empty.
//  4 Simultaneous wr_en&&rd_en at full -> read 1 word, overflow=1, count 8->7;
//    at empty -> write accepted, underflow=1, count 0->1.
//  5 FWFT=1: write 0xA5A5 -> data_out=0xA5A5 cycle after write with empty=0; rd_en -> empty.
//  6 Assert rst_n low mid-burst at count 5 -> count=0, empty=1, pulses 0 asynchronously;
//    subsequent write/read returns the new word, not stale data.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants and status bundle for the parametrised FIFO family.
// Used by the RTL and by anything that scoreboards FIFO status.
package fifo_pkg;

    localparam int FIFO_WIDTH_DEF = 16;
    localparam int FIFO_DEPTH_DEF = 8;

    typedef struct packed {
        logic full;
        logic almostfull;
        logic empty;
        logic almostempty;
        logic overflow;
        logic underflow;
        logic wr_ack;
    } fifo_status_t;

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-DEPTH pointer with explicit wrap at DEPTH-1.
// Works for depths that are not powers of two.
module fifo_wrap_ptr #(
    parameter int DEPTH = 8,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    // advance on inc, wrapping from the last entry back to zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (inc) begin
            if (ptr == PW'(DEPTH - 1)) begin
                ptr <= '0;
            end else begin
                ptr <= ptr + PW'(1);
            end
        end
    end

endmodule

// File: rtl/fifo_param_sync.sv
// Single-clock FIFO: any depth, almost-thresholds, optional FWFT,
// occupancy count and registered wr_ack/overflow/underflow pulses.
module fifo_param_sync
    import fifo_pkg::*;
#(
    parameter int WIDTH    = FIFO_WIDTH_DEF,
    parameter int DEPTH    = FIFO_DEPTH_DEF,
    parameter int AF_LEVEL = DEPTH - 1,
    parameter int AE_LEVEL = 1,
    parameter bit FWFT     = 1'b0,
    localparam int CW      = $clog2(DEPTH + 1),
    localparam int PW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             almostfull,
    output logic             empty,
    output logic             almostempty,
    output logic             overflow,
    output logic             underflow,
    output logic             wr_ack,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // a full FIFO rejects writes even when a read frees a slot this cycle
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    assign full        = (count == CW'(DEPTH));
    assign almostfull  = (count == CW'(AF_LEVEL));
    assign empty       = (count == '0);
    assign almostempty = (count == CW'(AE_LEVEL));

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wr_ok),
        .ptr   (wr_ptr)
    );

    fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (rd_ok),
        .ptr   (rd_ptr)
    );

    // storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // occupancy and one-cycle event pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            wr_ack    <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ack    <= wr_ok;
            overflow  <= wr_en && full;
            underflow <= rd_en && empty;
            if (wr_ok && !rd_ok) begin
                count <= count + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                count <= count - CW'(1);
            end
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign data_out = mem[rd_ptr];
        end else begin : g_reg
            logic [WIDTH-1:0] rd_q;

            // registered read; holds last word when no read occurs
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_q <= '0;
                end else if (rd_ok) begin
                    rd_q <= mem[rd_ptr];
                end
            end

            assign data_out = rd_q;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_param_sync.sv
// Directed bench for fifo_param_sync: depth 8 registered,
// depth 5 wrap, and depth 8 first-word-fall-through instances.
module tb_fifo_param_sync;
    import fifo_pkg::*;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    logic [15:0] a_din, a_dout;
    logic        a_wr, a_rd, a_full, a_af, a_empty, a_ae;
    logic        a_ovf, a_udf, a_ack;
    logic [3:0]  a_cnt;

    logic [15:0] b_din, b_dout;
    logic        b_wr, b_rd, b_full, b_af, b_empty, b_ae;
    logic        b_ovf, b_udf, b_ack;
    logic [2:0]  b_cnt;

    logic [15:0] c_din, c_dout;
    logic        c_wr, c_rd, c_full, c_af, c_empty, c_ae;
    logic        c_ovf, c_udf, c_ack;
    logic [3:0]  c_cnt;

    fifo_status_t a_st;

    assign a_st = '{full: a_full, almostfull: a_af, empty: a_empty,
                    almostempty: a_ae, overflow: a_ovf,
                    underflow: a_udf, wr_ack: a_ack};

    fifo_param_sync #(.WIDTH(16), .DEPTH(8), .FWFT(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .data_in(a_din), .wr_en(a_wr),
        .rd_en(a_rd), .data_out(a_dout), .full(a_full),
        .almostfull(a_af), .empty(a_empty), .almostempty(a_ae),
        .overflow(a_ovf), .underflow(a_udf), .wr_ack(a_ack),
        .count(a_cnt)
    );

    fifo_param_sync #(.WIDTH(16), .DEPTH(5), .FWFT(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .data_in(b_din), .wr_en(b_wr),
        .rd_en(b_rd), .data_out(b_dout), .full(b_full),
        .almostfull(b_af), .empty(b_empty), .almostempty(b_ae),
        .overflow(b_ovf), .underflow(b_udf), .wr_ack(b_ack),
        .count(b_cnt)
    );

    fifo_param_sync #(.WIDTH(16), .DEPTH(8), .FWFT(1'b1)) dut_c (
        .clk(clk), .rst_n(rst_n), .data_in(c_din), .wr_en(c_wr),
        .rd_en(c_rd), .data_out(c_dout), .full(c_full),
        .almostfull(c_af), .empty(c_empty), .almostempty(c_ae),
        .overflow(c_ovf), .underflow(c_udf), .wr_ack(c_ack),
        .count(c_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // structural invariants on the depth-8 registered instance
    always @(negedge clk) begin
        if (rst_n) begin
            assert (a_cnt <= 4'd8) else begin
                fails++;
                $error("FAIL inv_count observed=%0d expected<=8", a_cnt);
            end
            assert (!(a_full && a_empty)) else begin
                fails++;
                $error("FAIL inv_full_empty observed=11 expected=not 11");
            end
            assert (!(a_ack && a_ovf)) else begin
                fails++;
                $error("FAIL inv_ack_ovf observed=11 expected=not 11");
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        a_wr = 0; a_rd = 0; a_din = '0;
        b_wr = 0; b_rd = 0; b_din = '0;
        c_wr = 0; c_rd = 0; c_din = '0;

        #2;
        chk("rst_status", 32'(a_st), 32'b0010000);
        chk("rst_count", 32'(a_cnt), 0);
        chk("rst_dout", 32'(a_dout), 0);
        #10 rst_n = 1'b1;

        // 1: fill depth-8 FIFO, then overflow
        for (int i = 1; i <= 8; i++) begin
            a_wr = 1; a_din = 16'(i);
            step();
            chk($sformatf("t1_ack%0d", i), 32'(a_ack), 1);
            chk($sformatf("t1_cnt%0d", i), 32'(a_cnt), 32'(i));
            chk($sformatf("t1_af%0d", i), 32'(a_af), 32'(i == 7));
            chk($sformatf("t1_full%0d", i), 32'(a_full), 32'(i == 8));
        end
        a_din = 16'h0009;
        step();
        chk("t1_ovf", 32'(a_ovf), 1);
        chk("t1_ovf_ack", 32'(a_ack), 0);
        chk("t1_ovf_cnt", 32'(a_cnt), 8);

        // 2: drain in order, then underflow
        a_wr = 0; a_rd = 1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("t2_dout%0d", i), 32'(a_dout), 32'(i));
            chk($sformatf("t2_cnt%0d", i), 32'(a_cnt), 32'(8 - i));
            chk($sformatf("t2_ae%0d", i), 32'(a_ae), 32'(i == 7));
            chk($sformatf("t2_empty%0d", i), 32'(a_empty), 32'(i == 8));
        end
        chk("t2_ovf_clear", 32'(a_ovf), 0);
        step();
        chk("t2_udf", 32'(a_udf), 1);
        chk("t2_udf_hold", 32'(a_dout), 16'h0008);
        chk("t2_udf_cnt", 32'(a_cnt), 0);
        a_rd = 0;
        step();
        chk("t2_udf_clear", 32'(a_udf), 0);

        // 3: depth-5 wrap with count held in 2..4
        for (int v = 1; v <= 4; v++) begin
            b_wr = 1; b_din = 16'(v);
            step();
            chk($sformatf("t3_fill%0d", v), 32'(b_cnt), 32'(v));
        end
        chk("t3_af", 32'(b_af), 1);
        b_rd = 1;
        for (int v = 5; v <= 12; v++) begin
            b_din = 16'(v);
            step();
            chk($sformatf("t3_dout%0d", v), 32'(b_dout), 32'(v - 4));
            chk($sformatf("t3_cnt%0d", v), 32'(b_cnt), 4);
            chk($sformatf("t3_fe%0d", v), 32'({b_full, b_empty}), 0);
        end
        b_wr = 0;
        for (int v = 9; v <= 12; v++) begin
            step();
            chk($sformatf("t3_drain%0d", v), 32'(b_dout), 32'(v));
        end
        chk("t3_empty", 32'(b_empty), 1);
        b_rd = 0;

        // 4: simultaneous read/write at full and at empty
        a_rd = 0;
        for (int i = 0; i < 8; i++) begin
            a_wr = 1; a_din = 16'(16'h0010 + i);
            step();
        end
        chk("t4_full", 32'(a_full), 1);
        a_rd = 1; a_din = 16'h00FF;
        step();
        chk("t4f_cnt", 32'(a_cnt), 7);
        chk("t4f_ovf", 32'(a_ovf), 1);
        chk("t4f_ack", 32'(a_ack), 0);
        chk("t4f_dout", 32'(a_dout), 16'h0010);
        a_wr = 0;
        for (int i = 1; i < 8; i++) begin
            step();
        end
        chk("t4_drain_dout", 32'(a_dout), 16'h0017);
        chk("t4_drain_cnt", 32'(a_cnt), 0);
        a_wr = 1; a_din = 16'h0055;
        step();
        chk("t4e_cnt", 32'(a_cnt), 1);
        chk("t4e_udf", 32'(a_udf), 1);
        chk("t4e_ack", 32'(a_ack), 1);
        chk("t4e_dout_hold", 32'(a_dout), 16'h0017);
        a_wr = 0;
        step();
        chk("t4e_read", 32'(a_dout), 16'h0055);
        a_rd = 0;

        // 5: first-word-fall-through
        c_wr = 1; c_din = 16'hA5A5;
        step();
        chk("t5_empty", 32'(c_empty), 0);
        chk("t5_dout", 32'(c_dout), 16'hA5A5);
        c_wr = 0; c_rd = 1;
        step();
        chk("t5_empty_after", 32'(c_empty), 1);
        c_rd = 0; c_wr = 1; c_din = 16'h1111;
        step();
        c_din = 16'h2222;
        step();
        chk("t5_head1", 32'(c_dout), 16'h1111);
        c_wr = 0; c_rd = 1;
        step();
        chk("t5_head2", 32'(c_dout), 16'h2222);
        chk("t5_cnt", 32'(c_cnt), 1);
        c_rd = 0;

        // 6: async reset mid-burst
        for (int i = 0; i < 5; i++) begin
            a_wr = 1; a_din = 16'(16'h0020 + i);
            step();
        end
        chk("t6_cnt5", 32'(a_cnt), 5);
        chk("t6_ack_pre", 32'(a_ack), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_cnt", 32'(a_cnt), 0);
        chk("t6_rst_status", 32'(a_st), 32'b0010000);
        a_wr = 0;
        #2 rst_n = 1'b1;
        a_wr = 1; a_din = 16'hBEEF;
        step();
        chk("t6_new_cnt", 32'(a_cnt), 1);
        chk("t6_new_ack", 32'(a_ack), 1);
        a_wr = 0; a_rd = 1;
        step();
        chk("t6_new_dout", 32'(a_dout), 16'hBEEF);
        chk("t6_new_empty", 32'(a_empty), 1);
        a_rd = 0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
